// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first subtractor: {bout,diff} = a - b - bin, one bit per clock, with
// valid/ready handshakes on both sides. Define SERIAL_SUB_OVF_EN to add the signed-overflow port ovf.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             busy
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } stateT;

  stateT            state;
  stateT            nextState;
  logic [CW-1:0]    count;
  logic             borrow;
  logic [WIDTH-1:0] aSh;
  logic [WIDTH-1:0] bSh;
  logic [WIDTH-1:0] diffSh;

  logic             x;
  logic             y;
  logic             d;
  logic             borrowNext;
  logic             lastStep;
  logic [WIDTH-1:0] diffShNext;

  // One full-subtractor cell applied to the current LSBs and the registered borrow.
  assign x          = aSh[0];
  assign y          = bSh[0];
  assign d          = x ^ y ^ borrow;
  assign borrowNext = (~x & y) | (~(x ^ y) & borrow);
  assign diffShNext = {d, diffSh[WIDTH-1:1]};
  assign lastStep   = (count == CW'(WIDTH - 1));

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    // NOTE: default first so no path through the case leaves nextState unassigned (no latch).
    nextState = state;
    case (state)
      IDLE:    if (in_valid)  nextState = SHIFT;
      SHIFT:   if (lastStep)  nextState = DONE;
      DONE:    if (out_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      borrow <= 1'b0;
      aSh    <= '0;
      bSh    <= '0;
      diffSh <= '0;
      diff   <= '0;
      bout   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      state <= nextState;
      case (state)
        IDLE: begin
          if (in_valid) begin
            aSh    <= a;
            bSh    <= b;
            borrow <= bin;
            count  <= '0;
          end
        end
        SHIFT: begin
          borrow <= borrowNext;
          diffSh <= diffShNext;
          aSh    <= aSh >> 1;
          bSh    <= bSh >> 1;
          count  <= count + 1'b1;
          if (lastStep) begin
            diff <= diffShNext;
            bout <= borrowNext;
`ifdef SERIAL_SUB_OVF_EN
            // On the final step x/y are the captured operand MSBs and d is the result MSB.
            ovf  <= (x ^ y) & (x ^ d);
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: an arithmetic reference model with an expected-result
// queue is compared every cycle, plus directed vectors with hand-computed literal results.
module tb_serial_subtractor;

  localparam int WIDTH = 8;

  logic             clk       = 1'b0;
  logic             rst       = 1'b1;
  logic             in_valid  = 1'b0;
  logic             out_ready = 1'b0;
  logic             bin       = 1'b0;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             in_ready;
  logic             out_valid;
  logic             bout;
  logic             busy;
  logic [WIDTH-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic             ovf;
`endif

  int nVec = 0;
  int nErr = 0;
  int cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .bout     (bout),
    .busy     (busy)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             ovf;
    int               acceptCyc;
  } expT;

  expT expQ[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nVec++;
    if (act !== req) begin
      nErr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer arithmetic on the operands, unsigned for diff/bout, signed for ovf.
  function automatic expT model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                input logic c, input int acc);
    expT m;
    int  u;
    int  s;
    u = int'(x) - int'(y) - int'(c);
    s = int'($signed(x)) - int'($signed(y)) - int'(c);
    m.diff      = u[WIDTH-1:0];
    m.bout      = (u < 0);
    m.ovf       = (s < -(2 ** (WIDTH - 1))) || (s > (2 ** (WIDTH - 1)) - 1);
    m.acceptCyc = acc;
    return m;
  endfunction

  // Every cycle: handshake status and, while a result is due, its value against the model queue.
  always @(negedge clk) begin : compare
    logic ovExp;
    logic idleExp;
    if (rst) begin
      expQ.delete();
    end else begin
      idleExp = (expQ.size() == 0);
      ovExp   = !idleExp && (cyc >= expQ[0].acceptCyc + WIDTH);
      check("in_ready", in_ready, idleExp);
      check("busy", busy, !idleExp);
      check("out_valid", out_valid, ovExp);
      if (ovExp) begin
        check("model diff", diff, expQ[0].diff);
        check("model bout", bout, expQ[0].bout);
`ifdef SERIAL_SUB_OVF_EN
        check("model ovf", ovf, expQ[0].ovf);
`endif
        if (out_ready) void'(expQ.pop_front());
      end
      if (idleExp && in_valid) expQ.push_back(model(a, b, bin, cyc + 1));
    end
  end

  task automatic waitIdle(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready && !out_valid && !busy;
    end
    check({name, " idle reached"}, ok, 1'b1);
  endtask

  task automatic runOp(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                       input logic c, input logic [WIDTH-1:0] eDiff, input logic eBout,
                       input logic chkOvf, input logic eOvf, input int hold);
    logic found;
    @(posedge clk); #1;
    a = x; b = y; bin = c; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    found = 1'b0;
    for (int i = 0; i < WIDTH + 4 && !found; i++) begin
      @(negedge clk);
      found = out_valid;
    end
    check({name, " out_valid seen"}, found, 1'b1);
    check({name, " diff"}, diff, eDiff);
    check({name, " bout"}, bout, eBout);
`ifdef SERIAL_SUB_OVF_EN
    if (chkOvf) check({name, " ovf"}, ovf, eOvf);
`else
    if (chkOvf && eOvf) check({name, " ovf skipped"}, 1'b0, 1'b0 | eOvf);
`endif
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check({name, " hold out_valid"}, out_valid, 1'b1);
      check({name, " hold in_ready"}, in_ready, 1'b0);
      check({name, " hold diff"}, diff, eDiff);
      check({name, " hold bout"}, bout, eBout);
    end
    if (hold > 0) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      check({name, " still done"}, out_valid, 1'b1);
    end
    @(negedge clk);
    check({name, " back idle"}, in_ready, 1'b1);
    check({name, " out_valid low"}, out_valid, 1'b0);
    check({name, " diff retained"}, diff, eDiff);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: bench did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int   rises[$];
    logic prevOv;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", in_ready, 1'b1);
    check("reset out_valid", out_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    check("reset diff", diff, 8'h00);
    check("reset bout", bout, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    check("reset ovf", ovf, 1'b0);
`endif

    runOp("t1 5A-1F",   8'h5A, 8'h1F, 1'b0, 8'h3B, 1'b0, 1'b0, 1'b0, 0);
    runOp("t2 00-01",   8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 0);
    runOp("t2 10-10-1", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 0);
    runOp("t3 hold",    8'hC3, 8'h3C, 1'b1, 8'h86, 1'b0, 1'b0, 1'b0, 5);
    runOp("FF-FF-1",    8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 0);
    runOp("FF-00",      8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 0);
    runOp("00-FF-1",    8'h00, 8'hFF, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 0);

    // Continuous in_valid with changing operands: only captured ops run, WIDTH+2 apart.
    out_ready = 1'b1;
    prevOv    = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b1;
    for (int k = 0; k < 34; k++) begin
      a   = 8'(48 + k);
      b   = 8'(5 + 3 * k);
      bin = k[0];
      @(negedge clk);
      if (out_valid && !prevOv) rises.push_back(cyc);
      prevOv = out_valid;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("t4 rise count", (rises.size() >= 3), 1'b1);
    if (rises.size() >= 3) begin
      check("t4 spacing 1", rises[1] - rises[0], WIDTH + 2);
      check("t4 spacing 2", rises[2] - rises[1], WIDTH + 2);
    end
    waitIdle("t4");

    // Reset during the third SHIFT cycle aborts the operation.
    @(posedge clk); #1;
    a = 8'hAA; b = 8'h55; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t5 out_valid", out_valid, 1'b0);
    check("t5 busy", busy, 1'b0);
    check("t5 in_ready", in_ready, 1'b1);
    check("t5 diff cleared", diff, 8'h00);
    runOp("t5 09-03", 8'h09, 8'h03, 1'b0, 8'h06, 1'b0, 1'b0, 1'b0, 0);

    // Reset and in_valid together: operands must not be captured.
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; a = 8'h77; b = 8'h11;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst+valid busy", busy, 1'b0);
    check("rst+valid in_ready", in_ready, 1'b1);
    repeat (WIDTH + 1) @(negedge clk);
    check("rst+valid no result", out_valid, 1'b0);

`ifdef SERIAL_SUB_OVF_EN
    runOp("t6 80-01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1, 0);
    runOp("t6 7F-FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 1'b1, 0);
    runOp("t6 05-03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0, 0);
    runOp("ovf bin",  8'h80, 8'h00, 1'b1, 8'h7F, 1'b0, 1'b1, 1'b1, 0);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
